// File: rtl/klt_pkg.sv
// Shared constants for the KLT window accumulator and the 2x2 solver it feeds.
package klt_pkg;

   localparam int KLT_GRAD_W      = 10;
   localparam int KLT_WIN         = 7;
   localparam int KLT_ACC_W       = 26;
   localparam int KLT_SOLVER_IN_W = KLT_ACC_W;

   typedef enum logic [1:0] {
      ST_ACCUM = 2'd0,
      ST_DRAIN = 2'd1,
      ST_EMIT  = 2'd2
   } klt_state_t;

   // Sample counter wide enough to hold WIN*WIN and still detect overrun.
   function automatic int klt_cnt_width(input int win);
      return $clog2(win * win + 1);
   endfunction

endpackage

// File: rtl/klt_sat_acc.sv
// Signed accumulate-with-clear that clamps to +/-(2^(ACC_W-1)-1) and then holds.
module klt_sat_acc #(
   parameter int IN_W  = 20,
   parameter int ACC_W = 26
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_clear,
   input  logic             i_en,
   input  logic [IN_W-1:0]  i_din,
   output logic [ACC_W-1:0] o_acc,
   output logic             o_sat
);

   logic [ACC_W-1:0]      r_acc;
   logic                  r_sat;
   logic signed [ACC_W:0] w_sum;
   logic signed [ACC_W:0] w_max;
   logic signed [ACC_W:0] w_min;

   // One guard bit makes the overflow check a plain signed compare.
   assign w_max = {2'b00, {(ACC_W-1){1'b1}}};
   assign w_min = {2'b11, {(ACC_W-2){1'b0}}, 1'b1};
   assign w_sum = $signed({r_acc[ACC_W-1], r_acc})
                + $signed({{(ACC_W+1-IN_W){i_din[IN_W-1]}}, i_din});

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_acc <= '0;
         r_sat <= 1'b0;
      end else if (i_clear) begin
         r_acc <= '0;
         r_sat <= 1'b0;
      end else if (i_en && !r_sat) begin
         if (w_sum > w_max) begin
            r_acc <= w_max[ACC_W-1:0];
            r_sat <= 1'b1;
         end else if (w_sum < w_min) begin
            r_acc <= w_min[ACC_W-1:0];
            r_sat <= 1'b1;
         end else begin
            r_acc <= w_sum[ACC_W-1:0];
         end
      end
   end

   assign o_acc = r_acc;
   assign o_sat = r_sat;

endmodule

// File: rtl/klt_window_accumulator.sv
// Builds G11/G12/G22/b1/b2 over one WIN x WIN window for the KLT 2x2 solver.
//   state    | meaning
//   ST_ACCUM | accepting samples, product stage and accumulators running
//   ST_DRAIN | last product moving from product stage into accumulators
//   ST_EMIT  | register sums, pulse data_valid, clear for next window
module klt_window_accumulator
   import klt_pkg::*;
#(
   parameter int GRAD_W = KLT_GRAD_W,
   parameter int WIN    = KLT_WIN,
   parameter int ACC_W  = KLT_ACC_W
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic signed [GRAD_W-1:0] Ix,
   input  logic signed [GRAD_W-1:0] Iy,
   input  logic signed [GRAD_W-1:0] It,
   input  logic                    win_last,
   input  logic                    frame_end_in,
   output logic                    data_valid,
   output logic                    end_of_frame,
   output logic signed [ACC_W-1:0] G11,
   output logic signed [ACC_W-1:0] G12,
   output logic signed [ACC_W-1:0] G22,
   output logic signed [ACC_W-1:0] b1,
   output logic signed [ACC_W-1:0] b2,
   output logic                    win_error,
   output logic                    sat_flag
);

   localparam int PROD_W = 2 * GRAD_W;
   localparam int CNT_W  = klt_cnt_width(WIN);
   localparam logic [CNT_W-1:0] CNT_MAX  = '1;
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(WIN * WIN);

   klt_state_t                   r_state;
   logic                         r_in_ready;
   logic                         r_p_valid;
   logic [4:0][PROD_W-1:0]       r_prod;
   logic [CNT_W-1:0]             r_cnt;
   logic                         r_data_valid;
   logic                         r_end_of_frame;
   logic                         r_win_error;
   logic                         r_sat_flag;
   logic [4:0][ACC_W-1:0]        r_out;

   logic                         w_xfer;
   logic                         w_clear;
   logic signed [PROD_W-1:0]     w_ix;
   logic signed [PROD_W-1:0]     w_iy;
   logic signed [PROD_W-1:0]     w_it;
   logic [4:0][PROD_W-1:0]       w_prod;
   logic [4:0][ACC_W-1:0]        w_acc;
   logic [4:0]                   w_sat;

   assign w_xfer  = in_valid & r_in_ready;
   assign w_clear = frame_end_in | (r_state == ST_EMIT);

   assign w_ix = {{GRAD_W{Ix[GRAD_W-1]}}, Ix};
   assign w_iy = {{GRAD_W{Iy[GRAD_W-1]}}, Iy};
   assign w_it = {{GRAD_W{It[GRAD_W-1]}}, It};

   // Lane order: G11, G12, G22, b1, b2.
   assign w_prod[0] = w_ix * w_ix;
   assign w_prod[1] = w_ix * w_iy;
   assign w_prod[2] = w_iy * w_iy;
   assign w_prod[3] = w_ix * w_it;
   assign w_prod[4] = w_iy * w_it;

   for (genvar gi = 0; gi < 5; gi++) begin : g_acc
      klt_sat_acc #(
         .IN_W  (PROD_W),
         .ACC_W (ACC_W)
      ) u_acc (
         .clk     (clk),
         .rst     (rst),
         .i_clear (w_clear),
         .i_en    (r_p_valid),
         .i_din   (r_prod[gi]),
         .o_acc   (w_acc[gi]),
         .o_sat   (w_sat[gi])
      );
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state        <= ST_ACCUM;
         r_in_ready     <= 1'b0;
         r_p_valid      <= 1'b0;
         r_prod         <= '0;
         r_cnt          <= '0;
         r_data_valid   <= 1'b0;
         r_end_of_frame <= 1'b0;
         r_win_error    <= 1'b0;
         r_sat_flag     <= 1'b0;
         r_out          <= '0;
      end else begin
         r_end_of_frame <= frame_end_in;
         r_data_valid   <= 1'b0;
         r_win_error    <= 1'b0;
         r_sat_flag     <= 1'b0;
         if (frame_end_in) begin
            // Abort beats everything, including a coincident win_last.
            r_state    <= ST_ACCUM;
            r_in_ready <= 1'b0;
            r_p_valid  <= 1'b0;
            r_cnt      <= '0;
         end else begin
            r_p_valid <= w_xfer;
            if (w_xfer) r_prod <= w_prod;
            if (w_xfer && (r_cnt != CNT_MAX)) r_cnt <= r_cnt + 1'b1;
            case (r_state)
               ST_ACCUM: begin
                  if (w_xfer && win_last) begin
                     r_state    <= ST_DRAIN;
                     r_in_ready <= 1'b0;
                  end else begin
                     r_in_ready <= 1'b1;
                  end
               end
               ST_DRAIN: begin
                  r_state    <= ST_EMIT;
                  r_in_ready <= 1'b0;
               end
               ST_EMIT: begin
                  r_state      <= ST_ACCUM;
                  r_in_ready   <= 1'b1;
                  r_data_valid <= 1'b1;
                  r_out        <= w_acc;
                  r_win_error  <= (r_cnt != CNT_FULL);
                  r_sat_flag   <= |w_sat;
                  r_cnt        <= '0;
               end
               default: begin
                  r_state    <= ST_ACCUM;
                  r_in_ready <= 1'b0;
               end
            endcase
         end
      end
   end

   assign in_ready     = r_in_ready;
   assign data_valid   = r_data_valid;
   assign end_of_frame = r_end_of_frame;
   assign win_error    = r_win_error;
   assign sat_flag     = r_sat_flag;
   assign G11          = r_out[0];
   assign G12          = r_out[1];
   assign G22          = r_out[2];
   assign b1           = r_out[3];
   assign b2           = r_out[4];

endmodule

// File: tb/tb_klt_window_accumulator.sv
// Directed bench for klt_window_accumulator: default instance plus a narrow ACC_W=20 instance.
module tb_klt_window_accumulator;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic in_valid = 1'b0;
   logic win_last = 1'b0;
   logic frame_end_in = 1'b0;
   logic signed [9:0] Ix = '0;
   logic signed [9:0] Iy = '0;
   logic signed [9:0] It = '0;

   logic in_ready, data_valid, end_of_frame, win_error, sat_flag;
   logic signed [25:0] g11, g12, g22, gb1, gb2;

   logic s_in_ready, s_data_valid, s_end_of_frame, s_win_error, s_sat_flag;
   logic signed [19:0] s_g11, s_g12, s_g22, s_b1, s_b2;

   int n_vec  = 0;
   int n_miss = 0;
   int dv_cnt = 0;
   int cap_g11[16], cap_g12[16], cap_g22[16], cap_b1[16], cap_b2[16];
   int cap_err[16], cap_sat[16];

   always #5 clk = ~clk;

   klt_window_accumulator #(.GRAD_W(10), .WIN(7), .ACC_W(26)) u_dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .Ix(Ix), .Iy(Iy), .It(It), .win_last(win_last), .frame_end_in(frame_end_in),
      .data_valid(data_valid), .end_of_frame(end_of_frame),
      .G11(g11), .G12(g12), .G22(g22), .b1(gb1), .b2(gb2),
      .win_error(win_error), .sat_flag(sat_flag)
   );

   klt_window_accumulator #(.GRAD_W(10), .WIN(7), .ACC_W(20)) u_dut_sat (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(s_in_ready),
      .Ix(Ix), .Iy(Iy), .It(It), .win_last(win_last), .frame_end_in(frame_end_in),
      .data_valid(s_data_valid), .end_of_frame(s_end_of_frame),
      .G11(s_g11), .G12(s_g12), .G22(s_g22), .b1(s_b1), .b2(s_b2),
      .win_error(s_win_error), .sat_flag(s_sat_flag)
   );

   always @(negedge clk) begin
      if (data_valid) begin
         cap_g11[dv_cnt % 16] <= int'(g11);
         cap_g12[dv_cnt % 16] <= int'(g12);
         cap_g22[dv_cnt % 16] <= int'(g22);
         cap_b1[dv_cnt % 16]  <= int'(gb1);
         cap_b2[dv_cnt % 16]  <= int'(gb2);
         cap_err[dv_cnt % 16] <= int'(win_error);
         cap_sat[dv_cnt % 16] <= int'(sat_flag);
         dv_cnt <= dv_cnt + 1;
      end
   end

   task automatic chk(input string tag, input int obs, input int exp);
      n_vec++;
      if (obs !== exp) begin
         n_miss++;
         $display("FAIL %s: got %0d, want %0d", tag, obs, exp);
      end
   endtask

   // Called at a negedge; returns at the negedge right after the transfer edge.
   task automatic send(input int ix, input int iy, input int it, input logic last,
                       input logic fe, output int waits);
      int guard;
      guard = 0;
      Ix = ix[9:0];
      Iy = iy[9:0];
      It = it[9:0];
      in_valid = 1'b1;
      win_last = last;
      frame_end_in = fe;
      while (in_ready !== 1'b1 && guard < 20) begin
         @(negedge clk);
         guard++;
      end
      waits = guard;
      if (guard >= 20) chk("ready_timeout", guard, 0);
      @(negedge clk);
      in_valid = 1'b0;
      win_last = 1'b0;
      frame_end_in = 1'b0;
   endtask

   task automatic send_win(input int n, input int ix, input int iy, input int it,
                           input logic last_on_final);
      int w;
      for (int i = 0; i < n; i++) send(ix, iy, it, last_on_final && (i == n - 1), 1'b0, w);
   endtask

   task automatic wait_dv(input int target);
      int g;
      g = 0;
      while (dv_cnt < target && g < 20) begin
         @(negedge clk);
         g++;
      end
      if (dv_cnt < target) chk("dv_timeout", dv_cnt, target);
   endtask

   task automatic check_win(input string name, input int idx, input int e11, input int e12,
                            input int e22, input int eb1, input int eb2, input int eerr,
                            input int esat);
      chk({name, ".G11"}, cap_g11[idx % 16], e11);
      chk({name, ".G12"}, cap_g12[idx % 16], e12);
      chk({name, ".G22"}, cap_g22[idx % 16], e22);
      chk({name, ".b1"}, cap_b1[idx % 16], eb1);
      chk({name, ".b2"}, cap_b2[idx % 16], eb2);
      chk({name, ".win_error"}, cap_err[idx % 16], eerr);
      chk({name, ".sat_flag"}, cap_sat[idx % 16], esat);
   endtask

   initial begin
      int w;
      repeat (3) @(negedge clk);
      chk("rst.in_ready", in_ready, 0);
      chk("rst.data_valid", data_valid, 0);
      chk("rst.G11", g11, 0);
      chk("rst.b2", gb2, 0);
      chk("rst.end_of_frame", end_of_frame, 0);
      rst = 1'b0;
      @(negedge clk);
      chk("rst.in_ready_release", in_ready, 1);

      // Window A: 3/-2/5, latency and pulse shape checked cycle by cycle.
      send_win(49, 3, -2, 5, 1'b1);
      chk("A.dv_c1", data_valid, 0);
      chk("A.rdy_c1", in_ready, 0);
      @(negedge clk);
      chk("A.dv_c2", data_valid, 0);
      chk("A.rdy_c2", in_ready, 0);
      @(negedge clk);
      chk("A.dv_c3", data_valid, 1);
      chk("A.rdy_c3", in_ready, 1);
      chk("A.G11", g11, 441);
      chk("A.G12", g12, -294);
      chk("A.G22", g22, 196);
      chk("A.b1", gb1, 735);
      chk("A.b2", gb2, -490);
      chk("A.win_error", win_error, 0);
      chk("A.sat_flag", sat_flag, 0);
      @(negedge clk);
      chk("A.dv_pulse", data_valid, 0);
      chk("A.G11_hold", g11, 441);

      // Reset mid-window clears outputs and produces nothing.
      send_win(5, 7, 7, 7, 1'b0);
      rst = 1'b1;
      #1;
      chk("mrst.in_ready", in_ready, 0);
      chk("mrst.G11", g11, 0);
      chk("mrst.b1", gb1, 0);
      chk("mrst.data_valid", data_valid, 0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("mrst.in_ready_release", in_ready, 1);
      chk("mrst.no_dv", dv_cnt, 1);

      // Early win_last after 10 samples.
      send_win(10, 1, 1, 1, 1'b1);
      wait_dv(2);
      check_win("early", 1, 10, 10, 10, 10, 10, 1, 0);

      // Back-to-back windows with in_valid held: exactly two bubbles.
      send_win(49, 1, 2, 3, 1'b1);
      send(-1, 1, 2, 1'b0, 1'b0, w);
      chk("b2b.gap_cycles", w, 2);
      send_win(48, -1, 1, 2, 1'b1);
      wait_dv(4);
      check_win("B", 2, 49, 98, 196, 147, 294, 0, 0);
      check_win("C", 3, 49, -49, 49, -98, 98, 0, 0);

      // Abort on sample 20, then abort coinciding with win_last.
      send_win(19, 5, 5, 5, 1'b0);
      send(5, 5, 5, 1'b0, 1'b1, w);
      chk("abort.eof", end_of_frame, 1);
      chk("abort.in_ready", in_ready, 0);
      @(negedge clk);
      chk("abort.eof_drop", end_of_frame, 0);
      send_win(4, 5, 5, 5, 1'b0);
      send(5, 5, 5, 1'b1, 1'b1, w);
      repeat (6) @(negedge clk);
      chk("abort.no_dv", dv_cnt, 4);
      send_win(49, 2, -1, -3, 1'b1);
      wait_dv(5);
      check_win("D", 4, 196, -98, 49, -294, 147, 0, 0);

      // Extreme gradients: narrow instance saturates, default does not.
      send_win(49, -512, -512, 511, 1'b1);
      @(negedge clk);
      @(negedge clk);
      chk("sat.dv", s_data_valid, 1);
      chk("sat.G11", s_g11, 524287);
      chk("sat.G12", s_g12, 524287);
      chk("sat.G22", s_g22, 524287);
      chk("sat.b1", s_b1, -524287);
      chk("sat.b2", s_b2, -524287);
      chk("sat.sat_flag", s_sat_flag, 1);
      chk("wide.dv", data_valid, 1);
      chk("wide.G11", g11, 12845056);
      chk("wide.G12", g12, 12845056);
      chk("wide.b1", gb1, -12819968);
      chk("wide.sat_flag", sat_flag, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, want completion");
      $fatal(1, "watchdog expired");
   end

endmodule
